// File: rtl/checker_pkg.sv
// Shared types for the register file checker.
// FSM state encoding and counter width.
package checker_pkg;

  localparam int STATE_W = 3;
  localparam int CNT_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/expected_reg_store.sv
// Expected register values and care bits.
// One write port, one registered read port.
module expected_reg_store
  import checker_pkg::*;
#(
  parameter int DW = 32,
  parameter int RC = 32,
  parameter int IW = $clog2(RC)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          wcare_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  output logic          rcare_o
);

  logic [DW-1:0] mem_q [RC];
  logic [RC-1:0] care_q;
  logic [DW-1:0] rdata_q;
  logic          rcare_q;

  // Expected values are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      care_q  <= '0;
      rcare_q <= 1'b0;
    end else begin
      if (we_i) care_q[waddr_i] <= wcare_i;
      rcare_q <= care_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
  assign rcare_o = rcare_q;

endmodule

// File: rtl/reg_file_checker.sv
// Runs a program for RUN_CYCLES, then scans the
// register file and compares against expectations.
module reg_file_checker
  import checker_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  parameter int RUN_CYCLES = 100,
  parameter int IDX_W      = $clog2(REG_COUNT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  exp_we,
  input  logic [IDX_W-1:0]      exp_addr,
  input  logic [DATA_WIDTH-1:0] exp_data,
  input  logic                  exp_care,
  output logic [IDX_W-1:0]      rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  passed,
  output logic [IDX_W:0]        fail_count,
  output logic [IDX_W-1:0]      first_fail,
  output logic [DATA_WIDTH-1:0] first_fail_actual
);

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(REG_COUNT - 1);
  localparam logic [IDX_W:0] FMAX =
    (IDX_W+1)'(REG_COUNT);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       raddr_q;
  logic                   cmp_v_q;
  logic [IDX_W-1:0]       cmp_idx_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   passed_q;
  logic [IDX_W:0]         fcnt_q;
  logic [IDX_W:0]         fcnt_d;
  logic [IDX_W-1:0]       ff_q;
  logic [DATA_WIDTH-1:0]  ffa_q;
  logic [DATA_WIDTH-1:0]  st_data;
  logic                   st_care;
  logic                   st_we;
  logic                   mis;

  assign st_we = exp_we &&
                 state_q != ST_SCAN &&
                 state_q != ST_DRAIN;

  expected_reg_store #(
    .DW (DATA_WIDTH),
    .RC (REG_COUNT),
    .IW (IDX_W)
  ) u_store (
    .clock   (clock),
    .reset   (reset),
    .we_i    (st_we),
    .waddr_i (exp_addr),
    .wdata_i (exp_data),
    .wcare_i (exp_care),
    .raddr_i (raddr_q),
    .rdata_o (st_data),
    .rcare_o (st_care)
  );

  always_comb begin
    mis    = cmp_v_q && st_care &&
             (rf_rdata != st_data);
    fcnt_d = fcnt_q;
    if (mis && fcnt_q != FMAX)
      fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      raddr_q   <= '0;
      cmp_v_q   <= 1'b0;
      cmp_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      passed_q  <= 1'b0;
      fcnt_q    <= '0;
      ff_q      <= '0;
      ffa_q     <= '0;
    end else begin
      // Read data lags the address by one cycle.
      cmp_v_q   <= (state_q == ST_SCAN);
      cmp_idx_q <= raddr_q;
      fcnt_q    <= fcnt_d;
      if (mis && fcnt_q == '0) begin
        ff_q  <= cmp_idx_q;
        ffa_q <= rf_rdata;
      end
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            fcnt_q   <= '0;
            ff_q     <= '0;
            ffa_q    <= '0;
            done_q   <= 1'b0;
            passed_q <= 1'b0;
            busy_q   <= 1'b1;
            raddr_q  <= '0;
            cnt_q    <= CNT_W'(RUN_CYCLES);
            state_q  <= (RUN_CYCLES == 0) ?
                        ST_SCAN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_q   <= '0;
            state_q <= ST_SCAN;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SCAN: begin
          if (raddr_q == LAST) begin
            raddr_q <= '0;
            state_q <= ST_DRAIN;
          end else begin
            raddr_q <= raddr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          state_q  <= ST_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          passed_q <= (fcnt_d == '0);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rf_raddr          = raddr_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign passed            = passed_q;
  assign fail_count        = fcnt_q;
  assign first_fail        = ff_q;
  assign first_fail_actual = ffa_q;

endmodule

// File: doc/reg_file_checker.md
REG_FILE_CHECKER -- requirements
Module: reg_file_checker

Interface
REQ-001 Parameters SHALL be as follows.
  DATA_WIDTH, default 32, register width.
  REG_COUNT, default 32, number of registers checked (power of two, 2..64).
  RUN_CYCLES, default 100, number of clock cycles the program runs before scanning starts (0 is legal).
  IDX_W, default $clog2(REG_COUNT), register index width.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning).
  clock  in  1  rising-edge clock.
  reset  in  1  asynchronous active-high reset.
  start  in  1  one-cycle request to begin a check.
  exp_we  in  1  write strobe for an expected value.
  exp_addr  in  IDX_W  index of the expected value being written.
  exp_data  in  DATA_WIDTH  expected register value.
  exp_care  in  1  1 = compare this register, 0 = don't-care.
  rf_raddr  out  IDX_W  read address to the core register file.
  rf_rdata  in  DATA_WIDTH  register file read data, valid 1 cycle after rf_raddr.
  busy  out  1  high while a check is in progress.
  done  out  1  high while results are valid.
  passed  out  1  high when all cared-about registers matched.
  fail_count  out  IDX_W+1  number of mismatching registers.
  first_fail  out  IDX_W  lowest mismatching index.
  first_fail_actual  out  DATA_WIDTH  rf_rdata value observed at first_fail.

Function
REQ-004 The block SHALL implement states IDLE, RUN, SCAN, DRAIN, DONE.
REQ-005 In IDLE or DONE, start=1 SHALL clear all results, load the cycle counter with RUN_CYCLES, and enter RUN (or SCAN directly if RUN_CYCLES=0).
REQ-006 RUN SHALL decrement the counter each cycle and enter SCAN when the counter reaches 0, giving exactly RUN_CYCLES cycles in RUN.
REQ-007 SCAN SHALL drive rf_raddr = 0,1,...,REG_COUNT-1 on consecutive cycles, then enter DRAIN for 1 cycle, then DONE.
REQ-008 Compare SHALL occur 1 cycle after each address: a mismatch is counted only if exp_care[i]=1 and rf_rdata != expected[i].
REQ-009 On the first mismatch, first_fail and first_fail_actual SHALL be captured and then held; later mismatches SHALL only increment fail_count.
REQ-010 done SHALL be asserted RUN_CYCLES+REG_COUNT+1 cycles after the edge that sampled start, and SHALL stay high until the next accepted start or reset.
REQ-011 passed SHALL be high only in DONE, and only when fail_count=0.
REQ-012 busy SHALL be high in RUN, SCAN and DRAIN.
REQ-013 start SHALL be ignored while busy.
REQ-014 exp_we SHALL write expected[exp_addr] and care[exp_addr] in any state except SCAN and DRAIN; while in SCAN or DRAIN it SHALL be ignored.
REQ-015 rf_raddr SHALL be 0 outside SCAN.
REQ-016 fail_count SHALL not wrap; its maximum value is REG_COUNT.
REQ-017 With all care bits 0, the check SHALL complete and report passed=1.

Reset
REQ-018 Reset SHALL force state IDLE and zero the counter and all outputs: busy=0, done=0, passed=0, fail_count=0, first_fail=0, first_fail_actual=0, rf_raddr=0.
REQ-019 Reset SHALL clear all care bits to 0; expected values are not reset.
REQ-020 Reset asserted mid-RUN or mid-SCAN SHALL abort the check with no result retained.

Structure
REQ-021 The state enum and state encoding width SHALL live in a shared package, checker_pkg.
REQ-022 Expected values and care bits SHALL be held in one sub-module, expected_reg_store: 1 write port and 1 synchronous read port, read address aligned with rf_raddr.
REQ-023 The top level SHALL contain the FSM, counters, comparator and result registers, with no combinational path from rf_rdata to any output.

Verification
REQ-024 Load SRA expectations (a0=1, a1=3, a2=80000000, a3=7ffff000, a4=c0000000, a5=f0000000, a6=3ffff800, a7=0ffffe00; all others 0, all care=1), matching register file -> done at cycle 133, passed=1, fail_count=0.
REQ-025 Same load, but register 14 returns 40000000 -> passed=0, fail_count=1, first_fail=14, first_fail_actual=40000000.
REQ-026 As REQ-025, with care[14]=0 -> passed=1.
REQ-027 Registers 3 and 20 mismatch; start pulsed again at cycle 50 -> the second start is ignored, fail_count=2, first_fail=3.
REQ-028 Reset asserted at cycle 110 (during SCAN) -> all outputs 0, state IDLE; a new start then completes normally.
REQ-029 RUN_CYCLES=0, REG_COUNT=8 -> first rf_raddr=0 one cycle after start, done 9 cycles after start.
